// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule controller: expands one round key per clock into an
// internal table. Optional macro AES_KEYSCHED_REUSE_EN skips re-expanding an already-expanded key.
module aes_key_schedule_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic         key_ready_q;
    logic         busy_q;
    logic         keys_valid_q;
    logic [127:0] rk_q [NUM_ROUNDS+1];
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic         accept;
    logic         reuse_hit;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        w0  = k[127:96] ^ t;
        w1  = k[95:64] ^ w0;
        w2  = k[63:32] ^ w1;
        w3  = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        prev_key = rk_q[0];
        for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
            if (cnt_q == 4'(i)) prev_key = rk_q[i];
        end
        next_key = key_exp(prev_key, rcon(cnt_q));
    end

    assign accept = key_valid & key_ready_q;

`ifdef AES_KEYSCHED_REUSE_EN
    assign reuse_hit = keys_valid_q && (key_in == rk_q[0]);
`else
    assign reuse_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept && !reuse_hit) begin
                        rk_q[0]      <= key_in;
                        cnt_q        <= '0;
                        keys_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        key_ready_q  <= 1'b0;
                        state_q      <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
                        if (cnt_q == 4'(i - 1)) rk_q[i] <= next_key;
                    end
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(NUM_ROUNDS - 1)) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        keys_valid_q <= 1'b1;
                        key_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rk_data = '0;
        for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
            if (rk_addr == 4'(i)) rk_data = rk_q[i];
        end
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed bench for aes_key_schedule_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule_ctrl;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KEY_A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int unsigned n_checks;
    int unsigned n_errors;

    aes_key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input logic [3:0] addr, input string tag, input logic [127:0] exp);
        rk_addr = addr;
        #1;
        check(tag, rk_data, exp);
    endtask

    task automatic accept_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until keys_valid, bounded so a stuck DUT cannot hang the run
    task automatic wait_done(input string tag);
        int unsigned n;
        logic        busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        while (!keys_valid && n < 20) begin
            if (!busy || key_ready) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'd10);
        check({tag, "_busy_during"}, 128'(busy_ok), 128'd1);
        check({tag, "_busy_after"}, 128'(busy), 128'd0);
        check({tag, "_ready_after"}, 128'(key_ready), 128'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_addr   = '0;
        #22 rst_n = 1'b1;
        tick();
        tick();

        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        for (int a = 0; a < 16; a++) read_rk(4'(a), "rst_rk_zero", '0);

        // First key; a second key is offered throughout EXPAND and must be ignored
        accept_key(KEY_A);
        check("a_busy_after_accept", 128'(busy), 128'd1);
        check("a_ready_after_accept", 128'(key_ready), 128'd0);
        key_in    = KEY_B;
        key_valid = 1'b1;
        for (int c = 0; c < 9; c++) tick();
        key_valid = 1'b0;
        check("a_not_done_at_9", 128'(keys_valid), 128'd0);
        tick();
        check("a_done_at_10", 128'(keys_valid), 128'd1);
        check("a_busy_at_10", 128'(busy), 128'd0);
        read_rk(4'd0, "a_rk0", KEY_A);
        read_rk(4'd1, "a_rk1", KEY_A_R1);
        read_rk(4'd2, "a_rk2", KEY_A_R2);
        read_rk(4'd10, "a_rk10", KEY_A_R10);
        for (int a = 11; a < 16; a++) read_rk(4'(a), "a_rk_oob", '0);
        tick();
        check("a_keys_valid_hold", 128'(keys_valid), 128'd1);

        // Second key accepted from DONE; old high entries survive until rewritten
        accept_key(KEY_B);
        check("b_keys_valid_drop", 128'(keys_valid), 128'd0);
        read_rk(4'd10, "b_old_rk10", KEY_A_R10);
        wait_done("b");
        read_rk(4'd0, "b_rk0", KEY_B);
        read_rk(4'd1, "b_rk1", KEY_B_R1);
        read_rk(4'd10, "b_rk10", KEY_B_R10);

        // Reset in the middle of an expansion
        accept_key(KEY_A);
        for (int c = 0; c < 5; c++) tick();
        check("mid_busy_before_rst", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_ready", 128'(key_ready), 128'd1);
        check("mid_rst_keys_valid", 128'(keys_valid), 128'd0);
        for (int a = 0; a < 16; a++) read_rk(4'(a), "mid_rst_rk_zero", '0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_keys_valid", 128'(keys_valid), 128'd0);
        accept_key(KEY_B);
        wait_done("post_rst");
        read_rk(4'd1, "post_rst_rk1", KEY_B_R1);
        read_rk(4'd10, "post_rst_rk10", KEY_B_R10);

        // Re-presenting an already-expanded key
        accept_key(KEY_A);
        wait_done("reuse_setup");
        accept_key(KEY_A);
`ifdef AES_KEYSCHED_REUSE_EN
        for (int c = 0; c < 3; c++) begin
            check("reuse_keys_valid", 128'(keys_valid), 128'd1);
            check("reuse_busy", 128'(busy), 128'd0);
            check("reuse_ready", 128'(key_ready), 128'd1);
            tick();
        end
`else
        check("reuse_keys_valid_drop", 128'(keys_valid), 128'd0);
        check("reuse_busy", 128'(busy), 128'd1);
        wait_done("reuse");
`endif
        read_rk(4'd0, "reuse_rk0", KEY_A);
        read_rk(4'd1, "reuse_rk1", KEY_A_R1);
        read_rk(4'd10, "reuse_rk10", KEY_A_R10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
